shreg_seq: RTL



---
 rtl/shreg_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shreg_seq.sv
// Command sequencer for an external WIDTH-bit universal shift register: runs load/shift/rotate
// commands one step per cycle. Optional abort port pair enabled by `define SHREG_SEQ_ABORT_EN.
module shreg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             sr_l,
  output logic             sr_r,
  output logic             sr_i,
  output logic [WIDTH-1:0] sr_d,
  input  logic [WIDTH-1:0] sr_q,
  output logic             so,
  output logic             so_valid,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef SHREG_SEQ_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ILL0 = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHU  = 3'd2,
    OP_SHD  = 3'd3,
    OP_ROU  = 3'd4,
    OP_ROD  = 3'd5,
    OP_ASD  = 3'd6,
    OP_ILL7 = 3'd7
  } op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d, new_op;
  logic [CNT_W-1:0] step_q, step_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             aborted_q, aborted_d;
  logic             abort_now;
  logic             new_legal;

`ifdef SHREG_SEQ_ABORT_EN
  assign abort_now = abort;
  assign aborted   = (state_q == DONE) && aborted_q;
`else
  assign abort_now = 1'b0;
`endif

  assign new_op    = op_e'(cmd_op);
  assign new_legal = (new_op != OP_ILL0) && (new_op != OP_ILL7);
  assign result    = result_q;

  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path can infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    step_d    = step_q;
    fill_d    = fill_q;
    data_d    = data_q;
    result_d  = result_q;
    aborted_d = aborted_q;
    cmd_ready = 1'b0;
    sr_l      = 1'b0;
    sr_r      = 1'b0;
    sr_i      = 1'b0;
    sr_d      = '0;
    so        = 1'b0;
    so_valid  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d      = new_op;
          step_d    = (new_op == OP_LOAD) ? CNT_W'(1) : cmd_cnt;
          fill_d    = cmd_fill;
          data_d    = cmd_data;
          aborted_d = 1'b0;
          if (new_legal && (new_op == OP_LOAD || cmd_cnt != '0)) state_d = EXEC;
          else                                                    state_d = DONE;
        end
      end

      EXEC: begin
        if (abort_now) begin
          // Hold this cycle; the register keeps its partially shifted value.
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          so_valid = (op_q != OP_LOAD);
          case (op_q)
            OP_LOAD: begin sr_l = 1'b1; sr_r = 1'b1; sr_d = data_q; end
            OP_SHU:  begin sr_r = 1'b1; sr_i = fill_q;       so = sr_q[WIDTH-1]; end
            OP_SHD:  begin sr_l = 1'b1; sr_i = fill_q;       so = sr_q[0];       end
            OP_ROU:  begin sr_r = 1'b1; sr_i = sr_q[WIDTH-1]; so = sr_q[WIDTH-1]; end
            OP_ROD:  begin sr_l = 1'b1; sr_i = sr_q[0];       so = sr_q[0];       end
            OP_ASD:  begin sr_l = 1'b1; sr_i = sr_q[WIDTH-1]; so = sr_q[0];       end
            default: so_valid = 1'b0;
          endcase
          step_d = step_q - 1'b1;
          if (step_q <= CNT_W'(1)) state_d = DONE;
        end
      end

      DONE: begin
        done     = 1'b1;
        err      = (op_q == OP_ILL0) || (op_q == OP_ILL7);
        result_d = sr_q;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      op_q      <= OP_ILL0;
      step_q    <= '0;
      fill_q    <= 1'b0;
      data_q    <= '0;
      result_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
      state_q   <= state_d;
      op_q      <= op_d;
      step_q    <= step_d;
      fill_q    <= fill_d;
      data_q    <= data_d;
      result_q  <= result_d;
      aborted_q <= aborted_d;
    end
  end

endmodule
